// File: rtl/alu_pipe.sv
// Two-stage valid/ready pipelined N-bit ALU: s1 captures the beat, s2 computes and registers it.
// Define ALU_PIPE_FLAGS_EN to add the registered {V, C, Nf, Z} flags output.
module alu_pipe #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] operand1,
  input  logic [N-1:0] operand2,
  input  logic [2:0]   operation,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result
`ifdef ALU_PIPE_FLAGS_EN
  ,
  output logic [3:0]   flags
`endif
);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
    OP_XOR = 3'd4, OP_SHL = 3'd5, OP_SHR = 3'd6, OP_SLT = 3'd7
  } op_e;

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    op_e          op;
  } req_t;

  req_t         s1;
  logic         s1_v, s2_v;
  logic         s1_load, s2_load;
  logic [N-1:0] res_c;

  assign s2_load   = s1_v && (!s2_v || out_ready);
  assign in_ready  = !s1_v || s2_load;
  assign s1_load   = in_valid && in_ready;
  assign out_valid = s2_v;

  // Shift amounts >= N naturally zero-fill, giving the required 0 result.
  always_comb begin
    res_c = '0;
    unique case (s1.op)
      OP_ADD: res_c = s1.a + s1.b;
      OP_SUB: res_c = s1.a - s1.b;
      OP_AND: res_c = s1.a & s1.b;
      OP_OR:  res_c = s1.a | s1.b;
      OP_XOR: res_c = s1.a ^ s1.b;
      OP_SHL: res_c = s1.a << s1.b;
      OP_SHR: res_c = s1.a >> s1.b;
      OP_SLT: res_c = {{(N-1){1'b0}}, ($signed(s1.a) < $signed(s1.b))};
      default: res_c = '0;
    endcase
  end

`ifdef ALU_PIPE_FLAGS_EN
  logic [N:0] add_w, sub_w;
  logic       c_c, v_c;
  logic [3:0] flags_c;

  // Subtraction carry is taken from a + ~b + 1, so C=1 means no borrow.
  always_comb begin
    add_w = {1'b0, s1.a} + {1'b0, s1.b};
    sub_w = {1'b0, s1.a} + {1'b0, ~s1.b} + {{N{1'b0}}, 1'b1};
    c_c   = 1'b0;
    v_c   = 1'b0;
    if (s1.op == OP_ADD) begin
      c_c = add_w[N];
      v_c = (s1.a[N-1] == s1.b[N-1]) && (add_w[N-1] != s1.a[N-1]);
    end else if (s1.op == OP_SUB) begin
      c_c = sub_w[N];
      v_c = (s1.a[N-1] != s1.b[N-1]) && (sub_w[N-1] != s1.a[N-1]);
    end
    flags_c = {v_c, c_c, res_c[N-1], (res_c == '0)};
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1     <= '0;
      s1_v   <= 1'b0;
      s2_v   <= 1'b0;
      result <= '0;
`ifdef ALU_PIPE_FLAGS_EN
      flags  <= '0;
`endif
    end else begin
      if (s1_load) begin
        s1   <= '{a: operand1, b: operand2, op: op_e'(operation)};
        s1_v <= 1'b1;
      end else if (s2_load) begin
        s1_v <= 1'b0;
      end
      if (s2_load) begin
        s2_v   <= 1'b1;
        result <= res_c;
`ifdef ALU_PIPE_FLAGS_EN
        flags  <= flags_c;
`endif
      end else if (out_ready) begin
        s2_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (N=8): directed vectors plus a queue-based reference model.
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       resetn;
  logic       in_valid, in_ready;
  logic [7:0] operand1, operand2;
  logic [2:0] operation;
  logic       out_valid, out_ready;
  logic [7:0] result;
`ifdef ALU_PIPE_FLAGS_EN
  logic [3:0] flags;
`endif

  alu_pipe #(.N(8)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .operand1(operand1), .operand2(operand2), .operation(operation),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
`ifdef ALU_PIPE_FLAGS_EN
    , .flags(flags)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] r;
    logic [3:0] f;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_fail = 0, n_drained = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the opcode definitions.
  function automatic exp_t model(input int a, input int b, input int op);
    exp_t e;
    int   sa, sb, r, c, v;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    c = 0; v = 0; r = 0;
    case (op)
      0: begin r = (a + b) % 256; c = (a + b >= 256); v = (sa + sb > 127) || (sa + sb < -128); end
      1: begin r = (a - b + 256) % 256; c = (a >= b); v = (sa - sb > 127) || (sa - sb < -128); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (b >= 8) ? 0 : (a << b) % 256;
      6: r = (b >= 8) ? 0 : a >> b;
      default: r = (sa < sb) ? 1 : 0;
    endcase
    e.r = 8'(r);
    e.f = {v[0], c[0], (r >= 128), (r == 0)};
    return e;
  endfunction

  // Inputs change 1ns after posedge, so at negedge both sides are settled
  // and describe the handshake of the upcoming edge.
  always @(negedge clk) begin
    if (!resetn) begin
      q.delete();
    end else begin
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_out", out_valid, 1'b0);
        else begin
          chk("model_result", result, q[0].r);
`ifdef ALU_PIPE_FLAGS_EN
          chk("model_flags", flags, q[0].f);
`endif
          if (out_ready) begin
            void'(q.pop_front());
            n_drained++;
          end
        end
      end
      if (in_valid && in_ready) q.push_back(model(operand1, operand2, operation));
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    logic acc = 1'b0;
    operand1 = a; operand2 = b; operation = op; in_valid = 1'b1;
    for (int t = 0; t < 20 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    chk("send_accept", acc, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic check_one(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] op, input logic [7:0] er, input logic [3:0] ef);
    out_ready = 1'b1;
    send(a, b, op);
    chk({name, "_lat_s1"}, out_valid, 1'b0);
    @(posedge clk); #1;
    chk({name, "_lat_valid"}, out_valid, 1'b1);
    chk(name, result, er);
`ifdef ALU_PIPE_FLAGS_EN
    chk({name, "_flags"}, flags, ef);
`else
    if (ef === 4'hx) $display("unreachable");
`endif
  endtask

  initial begin
    logic [7:0] held;
    int         base;
    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    operand1 = '0; operand2 = '0; operation = '0;
    #2;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_result", result, 8'h00);
    chk("reset_in_ready", in_ready, 1'b1);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Directed vectors; flags are {V, C, Nf, Z}.
    check_one("add_7f_01", 8'h7F, 8'h01, 3'd0, 8'h80, 4'b1010);
    check_one("add_ff_01", 8'hFF, 8'h01, 3'd0, 8'h00, 4'b0101);
    check_one("sub_00_01", 8'h00, 8'h01, 3'd1, 8'hFF, 4'b0010);
    check_one("sub_05_03", 8'h05, 8'h03, 3'd1, 8'h02, 4'b0100);
    check_one("and",       8'hF0, 8'h3C, 3'd2, 8'h30, 4'b0000);
    check_one("or",        8'hF0, 8'h3C, 3'd3, 8'hFC, 4'b0010);
    check_one("xor",       8'hF0, 8'h3C, 3'd4, 8'hCC, 4'b0010);
    check_one("shl_81_3",  8'h81, 8'h03, 3'd5, 8'h08, 4'b0000);
    check_one("shr_81_7",  8'h81, 8'h07, 3'd6, 8'h01, 4'b0000);
    check_one("shl_ff_8",  8'hFF, 8'h08, 3'd5, 8'h00, 4'b0001);
    check_one("slt_fe_01", 8'hFE, 8'h01, 3'd7, 8'h01, 4'b0000);
    check_one("slt_01_fe", 8'h01, 8'hFE, 3'd7, 8'h00, 4'b0001);
    @(posedge clk); #1;

    // Back-to-back stream: accepted every cycle, all results drained in order.
    base = n_drained;
    for (int i = 0; i < 8; i++) begin
      operand1 = 8'($urandom_range(255)); operand2 = 8'($urandom_range(255));
      operation = 3'($urandom_range(7)); in_valid = 1'b1;
      @(negedge clk);
      chk("stream_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("stream_drained", n_drained - base, 8);

    // Backpressure: two beats fill the pipe, the third waits.
    out_ready = 1'b0;
    send(8'h11, 8'h22, 3'd0);
    send(8'h40, 8'h05, 3'd1);
    operand1 = 8'h0F; operand2 = 8'h02; operation = 3'd5; in_valid = 1'b1;
    @(negedge clk);
    held = result;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready_low", in_ready, 1'b0);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_result_hold", result, held);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(8'h0F, 8'h02, 3'd5);
    for (int t = 0; t < 20 && q.size() > 0; t++) begin
      @(posedge clk); #1;
    end
    chk("bp_drain_empty", q.size(), 0);

    // Reset with both stages full.
    out_ready = 1'b0;
    send(8'h01, 8'h02, 3'd0);
    send(8'h03, 8'h04, 3'd0);
    @(negedge clk);
    chk("full_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_result", result, 8'h00);
    chk("midrst_in_ready", in_ready, 1'b1);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_no_stale", out_valid, 1'b0);
    end
    @(posedge clk); #1;
    check_one("post_rst_add", 8'h10, 8'h20, 3'd0, 8'h30, 4'b0000);
    @(posedge clk); #1;
    chk("final_queue_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
